// File: rtl/ptmch_pkg.sv
// ptmch_pkg
// Shared definitions for the SPI-NAND pattern-match block:
//   - SPI-NAND opcode constants (also used by the CLK160M trigger block)
//   - cmd_class_e : command classification published to the trigger side
//   - seq_state_e : frame sequencer states
//   - decode_opc  : opcode -> command class lookup
package ptmch_pkg;

    localparam logic [7:0] OPC_PG_EXEC   = 8'h10;
    localparam logic [7:0] OPC_PG_READ   = 8'h13;
    localparam logic [7:0] OPC_BLK_ERASE = 8'hD8;
    localparam logic [7:0] OPC_GET_FEAT  = 8'h0F;
    localparam logic [7:0] OPC_RD_SR     = 8'h05;
    localparam logic [7:0] OPC_SET_FEAT  = 8'h1F;
    localparam logic [7:0] OPC_WR_SR     = 8'h01;

    typedef enum logic [2:0] {
        CLS_NONE      = 3'd0,
        CLS_PG_EXEC   = 3'd1,
        CLS_PG_READ   = 3'd2,
        CLS_BLK_ERASE = 3'd3,
        CLS_RD_STAT   = 3'd4,
        CLS_WR_STAT   = 3'd5,
        CLS_UNKNOWN   = 3'd6
    } cmd_class_e;

    typedef enum logic [2:0] {
        ST_OPC        = 3'd0,
        ST_ADDR_DUMMY = 3'd1,
        ST_ADDR       = 3'd2,
        ST_SR_ADDR    = 3'd3,
        ST_SR_DATA    = 3'd4,
        ST_RD_DATA    = 3'd5,
        ST_DONE       = 3'd6,
        ST_SKIP       = 3'd7
    } seq_state_e;

    // Map a captured opcode onto its command class.
    function automatic cmd_class_e decode_opc(input logic [7:0] opc);
        cmd_class_e cls_s;
        case (opc)
            OPC_PG_EXEC:   cls_s = CLS_PG_EXEC;
            OPC_PG_READ:   cls_s = CLS_PG_READ;
            OPC_BLK_ERASE: cls_s = CLS_BLK_ERASE;
            OPC_GET_FEAT:  cls_s = CLS_RD_STAT;
            OPC_RD_SR:     cls_s = CLS_RD_STAT;
            OPC_SET_FEAT:  cls_s = CLS_WR_STAT;
            OPC_WR_SR:     cls_s = CLS_WR_STAT;
            default:       cls_s = CLS_UNKNOWN;
        endcase
        return cls_s;
    endfunction

endpackage

// File: rtl/ptmch_spi_shreg.sv
// ptmch_spi_shreg
// 16-bit MSB-first shift register with a 3-bit wrapping bit counter.
// The "next" shift value and the byte strobe are presented combinationally
// so the sequencer can capture a complete byte on the very edge that
// clocks in its last bit.
// Ports:
//   SPI_CLK        in   SPI clock, MOSI sampled on rising edge
//   c_spi_reset_n  in   asynchronous active-low frame reset
//   SPI_MOSI       in   serial data, MSB first
//   shift_nxt_s    out  shift contents including the bit being sampled now
//   byte_stb_s     out  high while the current edge completes a byte
module ptmch_spi_shreg (
    input  logic        SPI_CLK,
    input  logic        c_spi_reset_n,
    input  logic        SPI_MOSI,
    output logic [15:0] shift_nxt_s,
    output logic        byte_stb_s
);

    logic [15:0] shift_r;
    logic [2:0]  bit_cnt_r;

    assign shift_nxt_s = {shift_r[14:0], SPI_MOSI};
    assign byte_stb_s  = (bit_cnt_r == 3'd7);

    // Shift in one bit per edge; the bit counter wraps modulo 8.
    always_ff @(posedge SPI_CLK or negedge c_spi_reset_n) begin
        if (!c_spi_reset_n) begin
            shift_r   <= 16'h0000;
            bit_cnt_r <= 3'd0;
        end else begin
            shift_r   <= shift_nxt_s;
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end
    end

endmodule

// File: rtl/ptmch_spi_seq.sv
// ptmch_spi_seq
// SPI_CLK-domain frame sequencer: follows one chip-select frame (each frame
// starts from reset), captures and classifies the opcode, captures the
// argument field and flags bits beyond a fixed-length command. Captured
// fields are write-once per frame so the CLK160M side can sample them
// through plain double-flop synchronisers.
// Ports:
//   SPI_CLK        in   SPI clock
//   c_spi_reset_n  in   asynchronous active-low reset (CS fall / global)
//   SPI_MOSI       in   serial data, MSB first
//   INST_CODE      out  captured opcode
//   INST_VLD       out  INST_CODE / CMD_CLASS valid
//   CMD_CLASS      out  command class
//   ARG            out  page address or {SR address, SR data}
//   ARG_VLD        out  ARG complete
//   DATA_CNT       out  saturating count of read-data bytes (RD_STAT)
//   OVERRUN        out  sticky: extra bits after a fixed-length command
module ptmch_spi_seq
    import ptmch_pkg::*;
#(
    parameter int unsigned P_DATA_CNT_W = 8
) (
    input  logic                    SPI_CLK,
    input  logic                    c_spi_reset_n,
    input  logic                    SPI_MOSI,
    output logic [7:0]              INST_CODE,
    output logic                    INST_VLD,
    output cmd_class_e              CMD_CLASS,
    output logic [15:0]             ARG,
    output logic                    ARG_VLD,
    output logic [P_DATA_CNT_W-1:0] DATA_CNT,
    output logic                    OVERRUN
);

    localparam logic [P_DATA_CNT_W-1:0] DATA_CNT_MAX = {P_DATA_CNT_W{1'b1}};
    localparam logic [P_DATA_CNT_W-1:0] DATA_CNT_ONE = {{(P_DATA_CNT_W-1){1'b0}}, 1'b1};

    logic [15:0] shift_nxt_s;
    logic        byte_stb_s;
    cmd_class_e  dec_cls_s;
    seq_state_e  state_r;
    logic [1:0]  phase_cnt_r;

    ptmch_spi_shreg u_shreg (
        .SPI_CLK       (SPI_CLK),
        .c_spi_reset_n (c_spi_reset_n),
        .SPI_MOSI      (SPI_MOSI),
        .shift_nxt_s   (shift_nxt_s),
        .byte_stb_s    (byte_stb_s)
    );

    assign dec_cls_s = decode_opc(shift_nxt_s[7:0]);

    // Frame sequencer: state, captured fields and flags, all registered.
    always_ff @(posedge SPI_CLK or negedge c_spi_reset_n) begin
        if (!c_spi_reset_n) begin
            state_r     <= ST_OPC;
            phase_cnt_r <= 2'd0;
            INST_CODE   <= 8'h00;
            INST_VLD    <= 1'b0;
            CMD_CLASS   <= CLS_NONE;
            ARG         <= 16'h0000;
            ARG_VLD     <= 1'b0;
            DATA_CNT    <= {P_DATA_CNT_W{1'b0}};
            OVERRUN     <= 1'b0;
        end else begin
            case (state_r)
                ST_OPC: begin
                    if (byte_stb_s) begin
                        INST_CODE <= shift_nxt_s[7:0];
                        INST_VLD  <= 1'b1;
                        CMD_CLASS <= dec_cls_s;
                        case (dec_cls_s)
                            CLS_PG_EXEC, CLS_PG_READ, CLS_BLK_ERASE: state_r <= ST_ADDR_DUMMY;
                            CLS_RD_STAT, CLS_WR_STAT:                state_r <= ST_SR_ADDR;
                            default:                                 state_r <= ST_SKIP;
                        endcase
                    end
                end
                ST_ADDR_DUMMY: begin
                    if (byte_stb_s) begin
                        state_r     <= ST_ADDR;
                        phase_cnt_r <= 2'd0;
                    end
                end
                ST_ADDR: begin
                    // Two address bytes; ARG is written only once both are in.
                    if (byte_stb_s) begin
                        if (phase_cnt_r == 2'd1) begin
                            ARG     <= shift_nxt_s;
                            ARG_VLD <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            phase_cnt_r <= phase_cnt_r + 2'd1;
                        end
                    end
                end
                ST_SR_ADDR: begin
                    if (byte_stb_s) begin
                        ARG[15:8] <= shift_nxt_s[7:0];
                        if (CMD_CLASS == CLS_RD_STAT) begin
                            ARG[7:0] <= 8'h00;
                            ARG_VLD  <= 1'b1;
                            state_r  <= ST_RD_DATA;
                        end else begin
                            state_r  <= ST_SR_DATA;
                        end
                    end
                end
                ST_SR_DATA: begin
                    if (byte_stb_s) begin
                        ARG[7:0] <= shift_nxt_s[7:0];
                        ARG_VLD  <= 1'b1;
                        state_r  <= ST_DONE;
                    end
                end
                ST_RD_DATA: begin
                    // Continuous read is legal: count bytes, never overrun.
                    if (byte_stb_s && (DATA_CNT != DATA_CNT_MAX)) begin
                        DATA_CNT <= DATA_CNT + DATA_CNT_ONE;
                    end
                end
                ST_DONE: begin
                    OVERRUN <= 1'b1;
                end
                ST_SKIP: begin
                    state_r <= ST_SKIP;
                end
                default: begin
                    state_r <= ST_OPC;
                end
            endcase
        end
    end

endmodule

// File: doc/ptmch_spi_seq.md
# ptmch_spi_seq

SPI_CLK-domain frame sequencer for the SPI-NAND pattern-match block. It follows each chip-select frame bit by bit and classifies the opcode. It captures the opcode's argument field (page address or status-register address/data) and flags protocol overruns. Each result is published as a write-once register that the CLK160M-side trigger logic samples through its synchronisers.

## Interface
Parameters:
- P_DATA_CNT_W, 8, width of the saturating data-byte counter

Ports:
- SPI_CLK  in  1  SPI clock; MOSI sampled on rising edge
- c_spi_reset_n  in  1  reset, asynchronous, active-low; asserted by CS falling edge or global reset; every frame starts from reset
- SPI_MOSI  in  1  serial data, MSB first
- INST_CODE  out  8  captured opcode
- INST_VLD  out  1  INST_CODE valid
- CMD_CLASS  out  3  cmd_class_e: NONE, PG_EXEC, PG_READ, BLK_ERASE, RD_STAT, WR_STAT, UNKNOWN
- ARG  out  16  page address (page ops) or {SR address, SR data} (status ops)
- ARG_VLD  out  1  ARG complete
- DATA_CNT  out  P_DATA_CNT_W  bytes clocked in data phase (RD_STAT only), saturating
- OVERRUN  out  1  extra bits after a fixed-length command

## Operation
- State machine: OPC → (ADDR_DUMMY → ADDR) | SR_ADDR → (SR_DATA | RD_DATA) → DONE; SKIP for unknown opcodes.
- OPC: shift 8 bits. On the 8th edge, latch INST_CODE, set INST_VLD and decode CMD_CLASS:
  - 0x10 → PG_EXEC, 0x13 → PG_READ, 0xD8 → BLK_ERASE; next state ADDR_DUMMY.
  - 0x0F / 0x05 → RD_STAT; next state SR_ADDR.
  - 0x1F / 0x01 → WR_STAT; next state SR_ADDR.
  - Any other value → UNKNOWN; next state SKIP.
- ADDR_DUMMY: 8 bits discarded. ADDR: 16 bits shifted; on the last edge, ARG ← page address and ARG_VLD = 1; next state DONE.
- SR_ADDR: 8 bits into ARG[15:8].
  - RD_STAT: on the 8th bit set ARG_VLD, ARG[7:0] = 0; next state RD_DATA.
  - WR_STAT: next state SR_DATA.
- SR_DATA: 8 bits into ARG[7:0]; on the 8th bit set ARG_VLD; next state DONE.
- RD_DATA: bit counter wraps every 8. DATA_CNT increments on each byte boundary and saturates at all-ones. Continuous read is legal, so OVERRUN is never set in this state.
- DONE: any further rising edge sets OVERRUN (sticky). All captured fields hold.
- SKIP: all edges ignored; INST_VLD = 1, ARG_VLD = 0, OVERRUN = 0.
- Write-once rule: INST_CODE, CMD_CLASS and ARG never change after their VLD bit is set within a frame. This is what makes CLK160M double-sync sampling safe.
- Frame shorter than the command (CS rises early): outputs freeze at their partial state. ARG_VLD stays 0, and the next CS-fall reset clears everything.

## Timing
- Reset values:
  - INST_CODE = 0x00, CMD_CLASS = NONE, ARG = 0x0000.
  - INST_VLD = 0, ARG_VLD = 0, DATA_CNT = 0, OVERRUN = 0, state = OPC, bit counter = 0.
- Edge counts are rising SPI_CLK edges since reset release. Every output is registered and updates on the edge named.
- INST_VLD rises on edge 8.
- ARG_VLD rises on edge 32 (page ops), edge 24 (WR_STAT) or edge 16 (RD_STAT).
- DATA_CNT = 1 on edge 24, then +1 every 8 edges.
- OVERRUN rises on edge 33 (page ops) or edge 25 (WR_STAT).
- Bit counter is 3 bits and wraps modulo 8; the phase byte counter is 2 bits.
- Reset asserted mid-frame: all state clears immediately (asynchronous); there is no partial-byte carry-over.

## Structure
- ptmch_pkg: opcode constants (shared with the trigger block), cmd_class_e, seq_state_e.
- Sub-module ptmch_spi_shreg: 16-bit MSB-first shift register plus 3-bit bit counter with a byte-boundary strobe. Instantiated once; the FSM consumes the strobe.

## Test plan
- Opcode 0x13, dummy 0x00, address 0x1234, CS high after edge 32 → CMD_CLASS = PG_READ; INST_VLD at edge 8; ARG = 0x1234 with ARG_VLD at edge 32; OVERRUN = 0.
- Opcode 0x1F, 0xA0, 0x7C → CMD_CLASS = WR_STAT; ARG = 0xA07C at edge 24. One extra bit → OVERRUN = 1 at edge 25, ARG unchanged.
- Opcode 0x0F, 0xC0, then 300 data bytes → ARG = 0xC000 at edge 16; DATA_CNT saturates at 255; OVERRUN = 0.
- Opcode 0x9F followed by 24 bits → CMD_CLASS = UNKNOWN, INST_VLD = 1, ARG_VLD = 0, ARG = 0x0000.
- Opcode 0xD8, reset pulsed at edge 20, then opcode 0x10 with address 0x00FF → first frame leaves no residue; second frame gives CMD_CLASS = PG_EXEC, ARG = 0x00FF.
- Opcode 0x10 with CS high after edge 12 → INST_VLD = 1, ARG_VLD = 0 held until next reset; no OVERRUN.
